// File: rtl/divider.sv
// Sequential 64-bit restoring radix-2 divider, one quotient bit per clock, 66-edge latency.
// Optional two's-complement mode is enabled by defining DIVIDER_SIGNED_EN.
module divider (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          op_start,
   input  logic          op_clear,
   input  logic [63:0]   dividend,
   input  logic [63:0]   divisor,
   output logic          op_done,
   output logic [127:0]  result,
   output logic          div_by_zero
);

   typedef enum logic [1:0] {
      INIT   = 2'b00,
      SET    = 2'b01,
      DIVIDE = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [63:0]    rem_q, rem_d;
   logic [63:0]    quo_q, quo_d;
   logic [63:0]    dvd_q, dvd_d;
   logic [63:0]    dvs_q, dvs_d;
   logic [127:0]   result_q, result_d;
   logic           dbz_q, dbz_d;

   // The stored partial remainder is always below the divisor, so 64 bits suffice;
   // the shifted value needs the extra bit during the trial subtraction.
   logic [64:0]    shifted;
   logic [64:0]    trial;
   logic [63:0]    rem_iter;
   logic [63:0]    quo_iter;
   logic [63:0]    fin_q;
   logic [63:0]    fin_r;
   logic [63:0]    dvd_mag;
   logic [63:0]    dvs_mag;

`ifdef DIVIDER_SIGNED_EN
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
`endif

   always_comb begin
      shifted  = {rem_q, quo_q[63]};
      trial    = shifted - {1'b0, dvs_q};
      quo_iter = {quo_q[62:0], ~trial[64]};
      rem_iter = trial[64] ? shifted[63:0] : trial[63:0];
`ifdef DIVIDER_SIGNED_EN
      dvd_mag  = dividend[63] ? -dividend : dividend;
      dvs_mag  = divisor[63]  ? -divisor  : divisor;
      fin_q    = qneg_q ? -quo_iter : quo_iter;
      fin_r    = rneg_q ? -rem_iter : rem_iter;
`else
      dvd_mag  = dividend;
      dvs_mag  = divisor;
      fin_q    = quo_iter;
      fin_r    = rem_iter;
`endif
      // Divide by zero still runs all iterations; only the packed result is overridden.
      if (dvs_q == 64'd0) begin
         fin_q = '1;
         fin_r = dvd_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      result_d = result_q;
      dbz_d    = dbz_q;
`ifdef DIVIDER_SIGNED_EN
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
`endif
      case (state_q)
         INIT: begin
            cnt_d    = 6'd0;
            result_d = '0;
            dbz_d    = 1'b0;
            if (op_start && !op_clear) begin
               state_d = SET;
            end
         end
         SET: begin
            dvd_d = dividend;
            dvs_d = dvs_mag;
            rem_d = 64'd0;
            quo_d = dvd_mag;
            cnt_d = 6'd0;
`ifdef DIVIDER_SIGNED_EN
            qneg_d = dividend[63] ^ divisor[63];
            rneg_d = dividend[63];
`endif
            state_d = op_clear ? INIT : DIVIDE;
         end
         DIVIDE: begin
            rem_d = rem_iter;
            quo_d = quo_iter;
            cnt_d = cnt_q + 6'd1;
            if (op_clear) begin
               state_d = INIT;
               cnt_d   = 6'd0;
            end else if (cnt_q == 6'd63) begin
               state_d  = DONE;
               result_d = {fin_r, fin_q};
               dbz_d    = (dvs_q == 64'd0);
            end
         end
         DONE: begin
            if (op_clear) begin
               state_d  = INIT;
               cnt_d    = 6'd0;
               result_d = '0;
               dbz_d    = 1'b0;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= INIT;
         cnt_q    <= 6'd0;
         rem_q    <= 64'd0;
         quo_q    <= 64'd0;
         dvd_q    <= 64'd0;
         dvs_q    <= 64'd0;
         result_q <= '0;
         dbz_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         result_q <= result_d;
         dbz_q    <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
`endif
      end
   end

   assign op_done     = (state_q == DONE);
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor checks each op_done rise.
// Signed vectors are exercised when DIVIDER_SIGNED_EN is defined.
module tb_divider;

   logic          clk;
   logic          reset_n;
   logic          op_start;
   logic          op_clear;
   logic [63:0]   dividend;
   logic [63:0]   divisor;
   logic          op_done;
   logic [127:0]  result;
   logic          div_by_zero;

   typedef struct {
      logic [127:0] res;
      logic         dbz;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic prev_done = 1'b0;

   divider dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .dividend    (dividend),
      .divisor     (divisor),
      .op_done     (op_done),
      .result      (result),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   // Monitor: compare against the scoreboard whenever op_done rises.
   always @(negedge clk) begin
      if (op_done && !prev_done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got result %h want no op_done", result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, " result"}, result, e.res);
            chk({e.name, " dbz"}, {127'd0, div_by_zero}, {127'd0, e.dbz});
         end
      end
      prev_done <= op_done;
   end

   // finish_mode: 0 ends with op_clear, 1 ends with an asynchronous reset while in DONE.
   task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eq, input logic [63:0] er, input logic edbz,
                         input bit scramble, input bit finish_mode);
      exp_t e;
      int   edges;
      logic done;
      bit   hold_ok;
      e.res  = {er, eq};
      e.dbz  = edbz;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      op_start = 1'b1;
      edges = 0;
      done  = 1'b0;
      while (!done && edges < 200) begin
         @(posedge clk);
         edges++;
         if (scramble && edges == 2) begin
            #1;
            dividend = ~a;
            divisor  = b + 64'd5;
         end
         @(negedge clk);
         done = op_done;
      end
      chk({name, " latency"}, 128'(edges), 128'd66);
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!op_done || result !== {er, eq}) hold_ok = 1'b0;
      end
      chk({name, " hold"}, {127'd0, hold_ok}, 128'd1);
      if (finish_mode == 1'b0) begin
         op_start = 1'b0;
         op_clear = 1'b1;
         @(posedge clk);
         #1;
         chk({name, " clear done"}, {127'd0, op_done}, 128'd0);
         chk({name, " clear result"}, result, 128'd0);
         op_clear = 1'b0;
      end else begin
         op_start = 1'b0;
         #2;
         reset_n = 1'b0;
         #1;
         chk({name, " async rst"}, {126'd0, op_done, div_by_zero}, 128'd0);
         chk({name, " async rst result"}, result, 128'd0);
         @(negedge clk);
         reset_n = 1'b1;
      end
   endtask

   task automatic watch_idle(input string nm, input int cycles);
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (op_done) quiet = 1'b0;
      end
      chk(nm, {127'd0, quiet}, 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      op_start = 1'b0;
      op_clear = 1'b0;
      dividend = 64'd0;
      divisor  = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {126'd0, op_done, div_by_zero}, 128'd0);
      chk("reset result", result, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset during DIVIDE, then a normal operation.
      @(negedge clk);
      dividend = 64'd100;
      divisor  = 64'd7;
      op_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op_start = 1'b0;
      repeat (31) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid-divide rst", {126'd0, op_done, div_by_zero}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      watch_idle("after rst idle", 80);

      run_op("100/7",      64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0);
      run_op("max/1",      64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 1'b0);
      run_op("5/9",        64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 1'b0, 1'b0);
      run_op("0x1234/0",   64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1'b0, 1'b0);
      run_op("1000/10 scr", 64'd1000, 64'd10, 64'd100, 64'd0, 1'b0, 1'b1, 1'b0);
      run_op("12345/100 rst", 64'd12345, 64'd100, 64'd123, 64'd45, 1'b0, 1'b0, 1'b1);
`ifndef DIVIDER_SIGNED_EN
      run_op("2^63/3",     64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 1'b0, 1'b0);
`else
      run_op("-7/2",       -64'sd7, 64'sd2, -64'sd3, -64'sd1, 1'b0, 1'b0, 1'b0);
      run_op("7/-2",       64'sd7, -64'sd2, -64'sd3, 64'sd1, 1'b0, 1'b0, 1'b0);
      run_op("min/-1",     64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 1'b0);
`endif

      // op_clear while DIVIDE counter is at 10.
      @(negedge clk);
      dividend = 64'd77;
      divisor  = 64'd3;
      op_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      op_start = 1'b0;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      op_clear = 1'b1;
      @(posedge clk);
      #1;
      op_clear = 1'b0;
      chk("clear mid-divide", {127'd0, op_done}, 128'd0);
      watch_idle("clear mid-divide idle", 80);

      // op_start and op_clear together in INIT must not leave INIT.
      @(negedge clk);
      dividend = 64'd50;
      divisor  = 64'd5;
      op_start = 1'b1;
      op_clear = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      op_clear = 1'b0;
      watch_idle("start+clear idle", 80);

      // Everything after a clean run must still work.
      run_op("9/4 again",  64'd9, 64'd4, 64'd2, 64'd1, 1'b0, 1'b0, 1'b0);

      chk("scoreboard drained", 128'(sb.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
